// File: rtl/tlb_fill.sv
// Two-level x86 page walk and TLB refill engine.
// Reads PDE then PTE over a single memory read port and writes one 44-bit entry into an 8-entry TLB.
module tlb_fill (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MISS_REQ,
  input  logic [19:0] MISS_VPN,
  input  logic [19:0] PDBR,
  input  logic [7:0]  VALID_VEC,
  output logic        BUSY,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        WR_EN,
  output logic [2:0]  WR_IDX,
  output logic [43:0] WR_DATA,
  output logic        DONE,
  output logic        FAULT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PDE_RD,
    S_PTE_RD,
    S_WRITE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] vpn_q, vpn_d;
  logic [19:0] pdbr_q, pdbr_d;
  logic [19:0] pde_base_q, pde_base_d;
  logic        pde_rw_q, pde_rw_d;
  logic [19:0] pte_rpn_q, pte_rpn_d;
  logic        pte_rw_q, pte_rw_d;
  logic        pte_pcd_q, pte_pcd_d;
  logic        fault_q, fault_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic [43:0] wr_data_q, wr_data_d;

  logic [2:0]  victim_idx;
  logic        all_valid;
  logic [43:0] new_entry;

  // Only the address, P, RW and PCD fields of the directory/table entries matter here.
  logic unused_rdata;
  assign unused_rdata = ^{MEM_RDATA[11:5], MEM_RDATA[3:2]};

  // Lowest free slot wins; round-robin only when every slot holds a valid entry.
  always_comb begin
    all_valid  = &VALID_VEC;
    victim_idx = rr_ptr_q;
    for (int i = 7; i >= 0; i--) begin
      if (!VALID_VEC[i]) victim_idx = 3'(i);
    end
  end

  assign new_entry = {vpn_q, pte_rpn_q, 1'b1, 1'b1, pde_rw_q & pte_rw_q, pte_pcd_q};

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    vpn_d      = vpn_q;
    pdbr_d     = pdbr_q;
    pde_base_d = pde_base_q;
    pde_rw_d   = pde_rw_q;
    pte_rpn_d  = pte_rpn_q;
    pte_rw_d   = pte_rw_q;
    pte_pcd_d  = pte_pcd_q;
    fault_d    = fault_q;
    rr_ptr_d   = rr_ptr_q;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (MISS_REQ) begin
          vpn_d   = MISS_VPN;
          pdbr_d  = PDBR;
          state_d = S_PDE_RD;
        end
      end
      S_PDE_RD: begin
        if (MEM_ACK) begin
          pde_base_d = MEM_RDATA[31:12];
          pde_rw_d   = MEM_RDATA[1];
          if (!MEM_RDATA[0]) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_PTE_RD;
          end
        end
      end
      S_PTE_RD: begin
        if (MEM_ACK) begin
          pte_rpn_d = MEM_RDATA[31:12];
          pte_rw_d  = MEM_RDATA[1];
          pte_pcd_d = MEM_RDATA[4];
          if (!MEM_RDATA[0]) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        wr_idx_d  = victim_idx;
        wr_data_d = new_entry;
        if (all_valid) rr_ptr_d = rr_ptr_q + 3'd1;
        state_d = S_DONE;
      end
      S_DONE: begin
        fault_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      vpn_q      <= '0;
      pdbr_q     <= '0;
      pde_base_q <= '0;
      pde_rw_q   <= 1'b0;
      pte_rpn_q  <= '0;
      pte_rw_q   <= 1'b0;
      pte_pcd_q  <= 1'b0;
      fault_q    <= 1'b0;
      rr_ptr_q   <= '0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      vpn_q      <= vpn_d;
      pdbr_q     <= pdbr_d;
      pde_base_q <= pde_base_d;
      pde_rw_q   <= pde_rw_d;
      pte_rpn_q  <= pte_rpn_d;
      pte_rw_q   <= pte_rw_d;
      pte_pcd_q  <= pte_pcd_d;
      fault_q    <= fault_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Outputs are pure decodes of registered state; the write port shows live values only in WRITE.
  always_comb begin
    BUSY     = (state_q != S_IDLE);
    MEM_REQ  = (state_q == S_PDE_RD) || (state_q == S_PTE_RD);
    MEM_ADDR = '0;
    if (state_q == S_PDE_RD) MEM_ADDR = {pdbr_q, vpn_q[19:10], 2'b00};
    if (state_q == S_PTE_RD) MEM_ADDR = {pde_base_q, vpn_q[9:0], 2'b00};
    WR_EN    = (state_q == S_WRITE);
    WR_IDX   = WR_EN ? victim_idx : wr_idx_q;
    WR_DATA  = WR_EN ? new_entry : wr_data_q;
    DONE     = (state_q == S_DONE);
    FAULT    = DONE && fault_q;
  end

endmodule
